// File: rtl/irq_priority_controller.sv
// Registered interrupt priority controller: N edge-triggered request lines,
// per-line enable mask, fixed-priority or round-robin arbitration.
// Latency: a REQ edge at cycle t is pending at t+1 and presented (IRQ_VALID) at t+2.
// Flow control: IRQ_VALID/IRQ_ID hold steady until ACK; no new presentation until COMPLETE.
//
// Ports:
//   CLK, RESET       rising-edge clock, asynchronous active-high reset
//   REQ[N]           level request lines; a rising edge sets the pending bit
//   EN_WE, EN_IN[N]  write strobe and new value for the per-line enable mask
//   MODE             0 = fixed priority (highest index), 1 = round-robin
//   ACK, COMPLETE    CPU accepts the presented ID / CPU finished servicing it
//   IRQ_VALID        an ID is being presented; qualifies IRQ_ID
//   IRQ_ID[IDW]      presented line index (holds its last value otherwise)
//   BUSY             CPU is servicing an interrupt
//   PENDING[N]       raw pending register, not masked by the enables
module irq_priority_controller #(
    parameter int N = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [N-1:0]         REQ,
    input  logic                 EN_WE,
    input  logic [N-1:0]         EN_IN,
    input  logic                 MODE,
    input  logic                 ACK,
    input  logic                 COMPLETE,
    output logic                 IRQ_VALID,
    output logic [$clog2(N)-1:0] IRQ_ID,
    output logic                 BUSY,
    output logic [N-1:0]         PENDING
);
    localparam int IDW = $clog2(N);

    typedef enum logic [1:0] {IDLE, PRESENT, SERVICE} state_t;

    state_t         state;
    logic [N-1:0]   pend;
    logic [N-1:0]   en;
    logic [N-1:0]   prev;
    logic [IDW-1:0] last;

    logic [N-1:0]   cand;
    logic           cand_any;
    logic [N-1:0]   clr;
    logic [IDW-1:0] fix_id;
    logic [IDW-1:0] rr_id;
    logic [IDW-1:0] sel_id;

    // Arbitration works only on registered state, so no input reaches an output
    // without passing a flop.
    assign cand     = pend & en;
    assign cand_any = |cand;

    // Fixed priority: ascending scan, so the highest set index is the last write.
    always_comb begin
        fix_id = '0;
        for (int i = 0; i < N; i++) begin
            if (cand[i]) fix_id = IDW'(i);
        end
    end

    // Round-robin: the scan order is LAST-1, LAST-2, ..., LAST (mod N). Walking
    // it backwards lets the first line in scan order make the final write, so
    // the most recently serviced line ends up with the lowest priority.
    always_comb begin
        int idx;
        idx   = 0;
        rr_id = '0;
        for (int k = N; k >= 1; k--) begin
            idx = int'(last) - k;
            if (idx < 0) idx = idx + N;
            if (cand[idx[IDW-1:0]]) rr_id = idx[IDW-1:0];
        end
    end

    assign sel_id = MODE ? rr_id : fix_id;

    // Clear only the line the CPU just accepted; a fresh edge on that line in
    // the same cycle is OR-ed back in afterwards, so the set wins.
    always_comb begin
        clr = '0;
        if (state == PRESENT && ACK) clr[IRQ_ID] = 1'b1;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            pend      <= '0;
            en        <= '0;
            prev      <= '0;
            last      <= '0;
            IRQ_VALID <= 1'b0;
            IRQ_ID    <= '0;
            BUSY      <= 1'b0;
        end else begin
            // prev is cleared by reset, so a line already high at release
            // counts as an edge on the first clock.
            prev <= REQ;
            pend <= (pend & ~clr) | (REQ & ~prev);
            if (EN_WE) en <= EN_IN;

            case (state)
                IDLE: begin
                    if (cand_any) begin
                        IRQ_ID    <= sel_id;
                        IRQ_VALID <= 1'b1;
                        state     <= PRESENT;
                    end
                end
                PRESENT: begin
                    // No preemption and no withdrawal: only ACK leaves here.
                    if (ACK) begin
                        IRQ_VALID <= 1'b0;
                        BUSY      <= 1'b1;
                        state     <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (COMPLETE) begin
                        last  <= IRQ_ID;
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign PENDING = pend;

endmodule

// File: tb/tb_irq_priority_controller.sv
// Self-checking bench for irq_priority_controller (N=16): directed scenarios
// with fixed expected IDs, then randomized traffic, every cycle compared
// against a behavioural model.
module tb_irq_priority_controller;
    localparam int N   = 16;
    localparam int IDW = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req = '0;
    logic           en_we = 1'b0;
    logic [N-1:0]   en_in = '0;
    logic           mode = 1'b0;
    logic           ack = 1'b0;
    logic           complete = 1'b0;
    logic           irq_valid;
    logic [IDW-1:0] irq_id;
    logic           busy;
    logic [N-1:0]   pending;

    int total = 0;
    int bad   = 0;

    irq_priority_controller #(.N(N)) dut (
        .CLK      (clk),
        .RESET    (rst),
        .REQ      (req),
        .EN_WE    (en_we),
        .EN_IN    (en_in),
        .MODE     (mode),
        .ACK      (ack),
        .COMPLETE (complete),
        .IRQ_VALID(irq_valid),
        .IRQ_ID   (irq_id),
        .BUSY     (busy),
        .PENDING  (pending)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference ----------------
    typedef enum {M_IDLE, M_PRES, M_SERV} mstate_t;
    mstate_t      m_st;
    logic [N-1:0] m_pend, m_en, m_prev;
    int           m_last, m_id;
    logic         m_valid, m_busy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Priority of line i: fixed mode ranks by index; round-robin ranks by how
    // far i sits behind LAST in the circular scan (LAST itself ranks lowest).
    function automatic int pick(input logic [N-1:0] c, input logic md, input int lst);
        int best;
        int bp;
        int p;
        best = 0;
        bp   = -1;
        for (int i = 0; i < N; i++) begin
            if (c[i]) begin
                p = md ? (i - lst + N) % N : i;
                if (p > bp) begin
                    bp   = p;
                    best = i;
                end
            end
        end
        return best;
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_pend = '0; m_en = '0; m_prev = '0;
        m_last = 0; m_id = 0; m_valid = 1'b0; m_busy = 1'b0;
    endtask

    // One clock: advance the model on the inputs present at the edge, then
    // compare every output a little after the edge.
    task automatic tick();
        logic [N-1:0] cnd;
        logic [N-1:0] clr;
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            cnd = m_pend & m_en;
            clr = '0;
            case (m_st)
                M_IDLE: if (cnd != 0) begin
                    m_id = pick(cnd, mode, m_last); m_valid = 1'b1; m_st = M_PRES;
                end
                M_PRES: if (ack) begin
                    clr[m_id] = 1'b1; m_valid = 1'b0; m_busy = 1'b1; m_st = M_SERV;
                end
                M_SERV: if (complete) begin
                    m_last = m_id; m_busy = 1'b0; m_st = M_IDLE;
                end
                default: ;
            endcase
            m_pend = (m_pend & ~clr) | (req & ~m_prev);
            if (en_we) m_en = en_in;
            m_prev = req;
        end
        #1;
        chk("valid", irq_valid, m_valid);
        if (m_valid) chk("id", irq_id, m_id);
        chk("busy", busy, m_busy);
        chk("pending", pending, m_pend);
    endtask

    task automatic pulse(input logic [N-1:0] m);
        req = m; tick(); req = '0;
    endtask

    task automatic write_en(input logic [N-1:0] v);
        en_we = 1'b1; en_in = v; tick(); en_we = 1'b0;
    endtask

    task automatic do_ack();
        ack = 1'b1; tick(); ack = 1'b0;
    endtask

    task automatic do_complete();
        complete = 1'b1; tick(); complete = 1'b0;
    endtask

    task automatic service();
        do_ack(); do_complete();
    endtask

    task automatic wait_valid(input string tag, input int exp_id);
        int n;
        n = 0;
        while (!irq_valid && n < 20) begin
            tick(); n++;
        end
        chk({tag, "_seen"}, irq_valid, 1);
        chk({tag, "_id"}, irq_id, exp_id);
    endtask

    task automatic do_reset();
        rst = 1'b1; model_reset();
        tick(); tick();
        rst = 1'b0;
    endtask

    initial begin
        model_reset();

        // Reset holds everything clear even with REQ toggling.
        #2;
        for (int i = 0; i < 4; i++) begin
            req = (i % 2 == 0) ? 16'hA5A5 : 16'h5A5A;
            tick();
        end
        chk("rst_pend", pending, 0);
        chk("rst_valid", irq_valid, 0);
        chk("rst_busy", busy, 0);
        req = '0;
        rst = 1'b0;
        write_en(16'hFFFF);
        repeat (5) tick();
        chk("idle_novalid", irq_valid, 0);

        // Fixed priority, exact latency.
        mode = 1'b0;
        pulse(16'h0208);
        chk("fx_lat_t1", irq_valid, 0);
        tick();
        chk("fx_lat_t2", irq_valid, 1);
        chk("fx_id9", irq_id, 9);
        do_ack();
        chk("fx_ack_pend", pending, 16'h0008);
        chk("fx_ack_busy", busy, 1);
        do_complete();
        chk("fx_cmp_novalid", irq_valid, 0);
        tick();
        chk("fx_next_valid", irq_valid, 1);
        chk("fx_next_id3", irq_id, 3);
        service();

        // Masking.
        write_en(16'h0008);
        pulse(16'h0208);
        wait_valid("mask", 3);
        service();
        chk("mask_pend9", pending, 16'h0200);
        repeat (3) tick();
        chk("mask_novalid", irq_valid, 0);
        write_en(16'h0200);
        wait_valid("mask_en9", 9);
        service();

        // Round-robin from LAST=0.
        do_reset();
        write_en(16'hFFFF);
        mode = 1'b1;
        pulse(16'h1024);
        wait_valid("rr_a", 12); service();
        wait_valid("rr_b", 5);  service();
        wait_valid("rr_c", 2);  service();
        pulse(16'h1020);
        wait_valid("rr_d", 12);
        do_ack();
        pulse(16'h4000);
        do_complete();
        wait_valid("rr_e", 5);  service();
        wait_valid("rr_f", 14); service();

        // Hold while presenting, and set-wins collision with ACK.
        mode = 1'b0;
        pulse(16'h0010);
        wait_valid("hold", 4);
        pulse(16'h8000);
        tick();
        chk("hold_id", irq_id, 4);
        chk("hold_valid", irq_valid, 1);
        req = 16'h0010; ack = 1'b1; tick(); req = '0; ack = 1'b0;
        chk("coll_pend4", pending[4], 1);
        do_complete();
        wait_valid("coll_15", 15); service();
        wait_valid("coll_4", 4);   service();

        // Asynchronous reset in SERVICE, between edges.
        pulse(16'h00C0);
        wait_valid("ar", 7);
        do_ack();
        chk("ar_busy", busy, 1);
        chk("ar_pend", pending, 16'h0040);
        #2;
        rst = 1'b1; model_reset();
        #1;
        chk("ar_busy0", busy, 0);
        chk("ar_valid0", irq_valid, 0);
        chk("ar_pend0", pending, 0);
        tick();
        rst = 1'b0;
        tick();
        chk("ar_idle", irq_valid, 0);

        // Randomized traffic.
        write_en(16'hFFFF);
        for (int c = 0; c < 3000; c++) begin
            req      = N'($urandom & $urandom & $urandom);
            en_we    = ($urandom_range(0, 15) == 0);
            en_in    = N'($urandom | $urandom);
            if ($urandom_range(0, 7) == 0) mode = ~mode;
            ack      = ($urandom_range(0, 2) == 0);
            complete = ($urandom_range(0, 2) == 0);
            rst      = ($urandom_range(0, 599) == 0);
            if (rst) model_reset();
            tick();
        end
        rst = 1'b0; req = '0; en_we = 1'b0; ack = 1'b0; complete = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/irq_priority_controller.md
Name: irq_priority_controller

Overview:
- Parametrised, registered successor to the combinational priority encoders in the RV32I core.
- Captures N interrupt request lines into a pending register and applies a per-line enable register.
- Selects one line by fixed priority (highest index wins) or round-robin.
- Presents the selected ID to the CPU through a valid/ack handshake, then holds off further interrupts until the CPU signals service completion.

Parameters:
- N, 16: number of request lines; legal range 2..32.
- IDW, $clog2(N): width of the ID output. Localparam, not overridable.

Ports:
- CLK  in  1  clock, rising-edge.
- RESET  in  1  asynchronous, active-high reset.
- REQ  in  N  request lines, synchronous to CLK, level; a rising edge sets the pending bit.
- EN_WE  in  1  write strobe for the enable register.
- EN_IN  in  N  new enable value; bit=1 means the line is enabled.
- MODE  in  1  0 = fixed priority, 1 = round-robin. Sampled only in IDLE.
- ACK  in  1  CPU accepts the presented ID.
- COMPLETE  in  1  CPU finished servicing.
- IRQ_VALID  out  1  an ID is presented.
- IRQ_ID  out  IDW  presented line index.
- BUSY  out  1  in SERVICE state.
- PENDING  out  N  pending register, raw and unmasked.

Behaviour:
- Reset (async) clears everything: PEND=0, EN=0, PREV=0, LAST=0, state=IDLE, IRQ_VALID=0, IRQ_ID=0, BUSY=0.
- Edge detect: PREV<=REQ every cycle. Set vector S = REQ & ~PREV.
  - A line already high at reset release registers an edge on the first clock.
- Pending update each cycle: PEND <= (PEND & ~C) | S.
  - C is the one-hot of IRQ_ID when the ACK is accepted, else 0.
  - Set wins: a new edge on the line being acked in the same cycle leaves its bit set.
- Enable update: when EN_WE=1, EN<=EN_IN. Candidate vector E = PEND & EN, computed from registered values.
- Fixed selection (MODE=0): highest set index of E.
- Round-robin selection (MODE=1): scan indices (LAST-1), (LAST-2), …, (LAST-N) mod N; the first set bit wins.
  - The most recently serviced line therefore gets lowest priority.
  - With LAST=0 the scan starts at N-1, matching fixed order.
- E=0 means no selection.
- FSM states: IDLE, PRESENT, SERVICE.
- IDLE:
  - If E≠0: IRQ_ID<=selection, IRQ_VALID<=1, go to PRESENT. IRQ_VALID rises one cycle after E becomes nonzero.
  - A pending bit set by an edge at cycle t is visible in E at t+1, so IRQ_VALID rises at t+2.
  - ACK and COMPLETE are ignored in IDLE.
- PRESENT:
  - IRQ_ID and IRQ_VALID are held stable. A higher-priority arrival does not preempt. Disabling the presented line via EN_WE does not withdraw it.
  - On ACK=1: clear PEND[IRQ_ID], IRQ_VALID<=0, BUSY<=1, go to SERVICE.
  - COMPLETE is ignored in PRESENT.
- SERVICE:
  - BUSY=1 and IRQ_VALID=0. Edges keep accumulating into PEND.
  - On COMPLETE=1: LAST<=IRQ_ID, BUSY<=0, go to IDLE. The next presentation can occur one cycle later at the earliest; no back-to-back presentation in the COMPLETE cycle.
  - ACK is ignored in SERVICE.
- IRQ_ID keeps its last value outside PRESENT. Only IRQ_VALID qualifies it.
- Simultaneous ACK+COMPLETE in PRESENT: ACK is taken and COMPLETE is ignored; the CPU must assert COMPLETE again in SERVICE.
- All outputs are registered; there is no combinational path from any input to any output.

Test Plan:
- Reset/idle (N=16): hold RESET, toggle REQ -> PENDING=0, IRQ_VALID=0, BUSY=0. After release with EN=0xFFFF and REQ=0 -> IRQ_VALID stays 0.
- Fixed priority: EN=0xFFFF, MODE=0, REQ[3] and REQ[9] rise in the same cycle t -> IRQ_VALID=1 with IRQ_ID=9 at t+2.
  - ACK -> PENDING=0x0008, BUSY=1. COMPLETE -> next presentation IRQ_ID=3.
- Masking: EN=0x0008, REQ[9] and REQ[3] pulse -> IRQ_ID=3 only, PENDING retains bit 9.
  - Later write EN=0x0200 -> IRQ_ID=9 presented.
- Round-robin: MODE=1, EN=0xFFFF, lines 2, 5, 12 pending, each serviced with ACK then COMPLETE.
  - Order is 12, 5, 2.
  - Re-raise 12 and 5 after servicing 2 (LAST=2) -> order 12, 5.
  - Service 12, then raise 14 while 5 is still pending -> 5 is presented before 14.
- Hold and collision:
  - In PRESENT with IRQ_ID=4, raise REQ[15] -> IRQ_ID stays 4.
  - Raise a new edge on REQ[4] in the same cycle as ACK -> PENDING[4] stays 1, and 4 is presented again after COMPLETE (15 wins first in fixed mode).
- Async reset mid-operation: assert RESET while in SERVICE, between clock edges -> BUSY, IRQ_VALID and PENDING go to 0 immediately, without waiting for a CLK edge. State returns to IDLE.
